// File: rtl/aec_result_fmt.sv
// Result formatter: buffers calculator results in a small FIFO and streams each one
// as decimal ASCII digits plus a 0x0A terminator. Define AEC_FMT_SIGNED_EN for signed input.
module aec_result_fmt #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [6:0] result,
  input  logic       ascii_ready,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  output logic       ovf
);

  localparam int AW = $clog2(DEPTH);

  // state     | meaning
  // IDLE      | waiting for a buffered result
  // LOAD      | pop FIFO head into working register, clear digit counters
  // CONV      | repeated subtraction, one step per cycle
  // SEND_SIGN | emit '-' for a negative result
  // SEND_H    | emit hundreds digit
  // SEND_T    | emit tens digit
  // SEND_O    | emit ones digit
  // SEND_TERM | emit 0x0A line terminator
  typedef enum logic [3:0] {
    IDLE, LOAD, CONV, SEND_SIGN, SEND_H, SEND_T, SEND_O, SEND_TERM
  } state_t;

  state_t state, state_nx, first_digit;

  logic [6:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [6:0]  head, head_mag;
  logic        head_neg;

  logic [6:0] work;
  logic [3:0] hund, tens;
  logic       neg;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = (state == LOAD);
  // A full FIFO still takes a new result when the head leaves in the same cycle.
  assign push  = valid && (!full || pop);
  assign head  = mem[rd_ptr[AW-1:0]];

`ifdef AEC_FMT_SIGNED_EN
  assign head_neg = head[6];
  assign head_mag = head[6] ? (~head + 7'd1) : head;
`else
  assign head_neg = 1'b0;
  assign head_mag = head;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (valid && !push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      work  <= '0;
      hund  <= '0;
      tens  <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: begin
          work <= head_mag;
          neg  <= head_neg;
          hund <= '0;
          tens <= '0;
        end
        CONV: begin
          if (work >= 7'd100) begin
            work <= work - 7'd100;
            hund <= hund + 4'd1;
          end else if (work >= 7'd10) begin
            work <= work - 7'd10;
            tens <= tens + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // A nonzero hundreds digit forces the tens digit out even when it is zero.
  always_comb begin
    if (hund != 4'd0)      first_digit = SEND_H;
    else if (tens != 4'd0) first_digit = SEND_T;
    else                   first_digit = SEND_O;
  end

  always_comb begin
    state_nx    = state;
    ascii_valid = 1'b0;
    ascii_out   = 8'h00;
    case (state)
      IDLE: if (!empty) state_nx = LOAD;
      LOAD: state_nx = CONV;
      CONV: if (work < 7'd10) state_nx = neg ? SEND_SIGN : first_digit;
      SEND_SIGN: begin
        ascii_valid = 1'b1;
        ascii_out   = 8'h2D;
        if (ascii_ready) state_nx = first_digit;
      end
      SEND_H: begin
        ascii_valid = 1'b1;
        ascii_out   = 8'h30 + {4'h0, hund};
        if (ascii_ready) state_nx = SEND_T;
      end
      SEND_T: begin
        ascii_valid = 1'b1;
        ascii_out   = 8'h30 + {4'h0, tens};
        if (ascii_ready) state_nx = SEND_O;
      end
      SEND_O: begin
        ascii_valid = 1'b1;
        ascii_out   = 8'h30 + {1'b0, work};
        if (ascii_ready) state_nx = SEND_TERM;
      end
      SEND_TERM: begin
        ascii_valid = 1'b1;
        ascii_out   = 8'h0A;
        if (ascii_ready) state_nx = empty ? IDLE : LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/aec_result_fmt.md
AEC_RESULT_FMT -- requirements
Module: aec_result_fmt

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port valid, input, 1: one-cycle pulse from the expression calculator marking a new result.
REQ-004 SHALL have port result, input, 7: calculator result, sampled only when valid=1.
REQ-005 SHALL have port ascii_ready, input, 1: downstream sink accepts ascii_out this cycle.
REQ-006 SHALL have port ascii_out, output, 8: current ASCII character.
REQ-007 SHALL have port ascii_valid, output, 1: ascii_out holds a character awaiting acceptance.
REQ-008 SHALL have port ovf, output, 1: sticky flag, a result was dropped because the FIFO was full.
REQ-009 SHALL have parameter DEPTH, default 4, meaning result FIFO depth (power of two, 2..16).

Function
REQ-010 SHALL push result into a DEPTH-entry FIFO on every cycle with valid=1 and FIFO not full.
REQ-011 SHALL accept the push when FIFO is full only if a pop occurs in the same cycle; otherwise SHALL drop the result and set ovf=1.
REQ-012 SHALL implement states IDLE, LOAD, CONV, SEND_SIGN, SEND_H, SEND_T, SEND_O, SEND_TERM.
REQ-013 IDLE->LOAD when FIFO non-empty; LOAD pops the head into a working register and clears the hundreds/tens counters.
REQ-014 CONV, one step per cycle: value>=100 -> subtract 100, hundreds+1; else value>=10 -> subtract 10, tens+1; else exit; remainder = ones.
REQ-015 CONV exit SHALL go to SEND_SIGN when the sign is to be printed (REQ-025), else to the first printed digit state.
REQ-016 Leading zeros SHALL be suppressed: SEND_H skipped if hundreds=0; SEND_T skipped if hundreds=0 and tens=0; SEND_O always sent.
REQ-017 Digits SHALL be encoded as 0x30+digit; SEND_TERM SHALL emit 0x0A; after SEND_TERM is accepted -> IDLE (or LOAD if FIFO non-empty).
REQ-018 In every SEND_* state ascii_valid=1; the state advances only on ascii_valid&&ascii_ready; ascii_out SHALL stay stable while ascii_ready=0.
REQ-019 ascii_valid SHALL be 0 in IDLE, LOAD and CONV.
REQ-020 With formatter in IDLE and FIFO empty, the first ascii_valid SHALL assert no more than 14 cycles after the valid pulse.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an extra pointer bit or an occupancy counter.
REQ-022 Results SHALL be emitted in arrival order, each exactly once.

Reset
REQ-023 While rst=0: ascii_valid=0, ascii_out=0x00, ovf=0, FSM=IDLE, FIFO empty; any in-progress conversion or transfer SHALL be abandoned without emitting further characters.
REQ-024 After rst deasserts, the first valid pulse SHALL be accepted normally.

Configuration
REQ-025 Macro AEC_FMT_SIGNED_EN defined: result SHALL be read as 7-bit two's complement (-64..63); negative values SHALL emit 0x2D ('-') in SEND_SIGN followed by the magnitude digits.
REQ-026 Macro AEC_FMT_SIGNED_EN undefined: result SHALL be read as unsigned (0..127); SEND_SIGN SHALL never be entered.

Verification
REQ-027 Unsigned: valid with result=7 -> "7",0x0A (0x37,0x0A).
REQ-028 Unsigned: result=127 -> 0x31,0x32,0x37,0x0A; result=100 -> 0x31,0x30,0x30,0x0A; result=0 -> 0x30,0x0A.
REQ-029 Backpressure: result=45 with ascii_ready low for 5 cycles on each character -> 0x34,0x35,0x0A, each held stable until accepted, no duplicates.
REQ-030 Overflow (DEPTH=4, ascii_ready=0): six valid pulses with 1..6 -> ovf=1; after ascii_ready=1, output is 1..5 in order (one in working register, four in FIFO), 6 lost.
REQ-031 Signed build: result=7'h7F -> 0x2D,0x31,0x0A; result=7'h40 -> 0x2D,0x36,0x34,0x0A; result=63 -> 0x36,0x33,0x0A.
REQ-032 Reset mid-output: rst=0 after 0x31 of "123" -> ascii_valid=0, ovf=0 immediately; no residual characters after release.
